// File: rtl/cpu_types_pkg.sv
// Shared CPU types: opcodes, word/register widths and the MEM-stage FSM states.
// Consumed by the MEM stage and its LL/SC link register.
package cpu_types_pkg;
  localparam int WORD_W = 32;
  localparam int REG_W  = 5;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [REG_W-1:0]  regbits_t;

  typedef enum logic [5:0] {
    RTYPE = 6'b000000,
    LW    = 6'b100011,
    SW    = 6'b101011,
    LL    = 6'b110000,
    SC    = 6'b111000
  } opcode_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } mem_state_t;
endpackage

// File: rtl/llsc_link.sv
// LL/SC link register: set on LL, cleared on SC/SW-to-link/snoop hit; set beats snoop.
// match_o already folds in a same-cycle snoop hit so an invalidate beats an SC check.
module llsc_link #(
  parameter int WORD_W = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              set_i,
  input  logic [WORD_W-1:0] set_addr_i,
  input  logic              clr_i,
  input  logic              snoop_vld_i,
  input  logic [WORD_W-1:0] snoop_addr_i,
  input  logic [WORD_W-1:0] chk_addr_i,
  output logic              match_o,
  output logic              link_valid_o,
  output logic [WORD_W-1:0] link_addr_o
);
  logic              link_valid_q, link_valid_d;
  logic [WORD_W-1:0] link_addr_q, link_addr_d;
  logic              snoop_hit;

  assign snoop_hit = snoop_vld_i & link_valid_q &
                     ({snoop_addr_i[WORD_W-1:2], 2'b00} == link_addr_q);

  always_comb begin
    link_valid_d = link_valid_q;
    link_addr_d  = link_addr_q;
    if (set_i) begin
      link_valid_d = 1'b1;
      link_addr_d  = {set_addr_i[WORD_W-1:2], 2'b00};
    end else if (clr_i || snoop_hit) begin
      link_valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      link_valid_q <= 1'b0;
      link_addr_q  <= '0;
    end else begin
      link_valid_q <= link_valid_d;
      link_addr_q  <= link_addr_d;
    end
  end

  assign match_o      = link_valid_q & ~snoop_hit &
                        (link_addr_q == {chk_addr_i[WORD_W-1:2], 2'b00});
  assign link_valid_o = link_valid_q;
  assign link_addr_o  = link_addr_q;
endmodule

// File: rtl/mem_stage.sv
// MEM stage: issues dcache LW/SW/LL/SC, stalls IF..EX/MEM until dhit; non-mem ops pass in 0 cycles.
// Mem op latency 1 + N(REQ) + 1; `define LLSC_EN enables the link register and SC fail semantics.
module mem_stage
  import cpu_types_pkg::*;
#(
  parameter int WORD_W = cpu_types_pkg::WORD_W,
  parameter int REG_W  = cpu_types_pkg::REG_W
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              ex_valid,
  input  logic              squash,
  input  opcode_t           opcode_i,
  input  logic [WORD_W-1:0] alu_out_i,
  input  logic [WORD_W-1:0] store_i,
  input  logic [WORD_W-1:0] npc_i,
  input  logic              RegW_i,
  input  logic [REG_W-1:0]  RegDest_i,
  input  logic              halt_i,
  input  logic              dhit,
  input  logic [WORD_W-1:0] dmemload,
  input  logic              ccinv,
  input  logic [WORD_W-1:0] ccsnoopaddr,
  output logic              dmemREN,
  output logic              dmemWEN,
  output logic [WORD_W-1:0] dmemaddr,
  output logic [WORD_W-1:0] dmemstore,
  output logic              mem_stall,
  output logic [WORD_W-1:0] Mem_o,
  output logic [WORD_W-1:0] npc_o,
  output logic [WORD_W-1:0] Addr_o,
  output logic              RegW_o,
  output logic [REG_W-1:0]  RegDest_o,
  output logic              halt_o,
  output logic [WORD_W-1:0] alu_out_o,
  output opcode_t           opcode_o
);
  mem_state_t        state_q, state_d;
  opcode_t           req_op_q, req_op_d;
  logic [WORD_W-1:0] req_addr_q, req_addr_d;
  logic [WORD_W-1:0] req_data_q, req_data_d;
  logic [WORD_W-1:0] load_q, load_d;
  logic [WORD_W-1:0] mem_res;
  logic              memop, is_sc, sc_ok, issue, stall, ren, wen, done;
  logic              req_rd;

  assign memop  = ex_valid & ~squash &
                  (opcode_i == LW || opcode_i == SW || opcode_i == LL || opcode_i == SC);
  assign is_sc  = (opcode_i == SC);
  assign issue  = memop & (~is_sc | sc_ok);
  assign req_rd = (req_op_q == LW) || (req_op_q == LL);

`ifdef LLSC_EN
  logic              link_set, link_clr, link_valid;
  logic [WORD_W-1:0] link_addr;

  assign link_set = done & (req_op_q == LL);
  assign link_clr = done & ((req_op_q == SC) ||
                            ((req_op_q == SW) && (req_addr_q == link_addr)));

  llsc_link #(.WORD_W(WORD_W)) u_link (
    .CLK          (CLK),
    .nRST         (nRST),
    .set_i        (link_set),
    .set_addr_i   (req_addr_q),
    .clr_i        (link_clr),
    .snoop_vld_i  (ccinv),
    .snoop_addr_i (ccsnoopaddr),
    .chk_addr_i   (alu_out_i),
    .match_o      (sc_ok),
    .link_valid_o (link_valid),
    .link_addr_o  (link_addr)
  );
`else
  logic unused_cc;
  assign unused_cc = ^{ccinv, ccsnoopaddr};
  assign sc_ok     = 1'b1;
`endif

  always_comb begin
    state_d    = state_q;
    req_op_d   = req_op_q;
    req_addr_d = req_addr_q;
    req_data_d = req_data_q;
    load_d     = load_q;
    mem_res    = '0;
    stall      = 1'b0;
    ren        = 1'b0;
    wen        = 1'b0;
    done       = 1'b0;
    case (state_q)
      IDLE: begin
        if (issue) begin
          state_d    = REQ;
          req_op_d   = opcode_i;
          req_addr_d = {alu_out_i[WORD_W-1:2], 2'b00};
          req_data_d = store_i;
          stall      = 1'b1;
        end
      end
      REQ: begin
        stall = 1'b1;
        ren   = req_rd;
        wen   = ~req_rd;
        if (dhit) begin
          state_d = DONE;
          if (req_rd) load_d = dmemload;
        end
      end
      DONE: begin
        // EX/MEM still holds this instruction; it is retired here, never re-issued.
        state_d = IDLE;
        done    = 1'b1;
        mem_res = (req_op_q == SC) ? {{(WORD_W-1){1'b0}}, 1'b1} : load_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= IDLE;
      req_op_q   <= RTYPE;
      req_addr_q <= '0;
      req_data_q <= '0;
      load_q     <= '0;
    end else begin
      state_q    <= state_d;
      req_op_q   <= req_op_d;
      req_addr_q <= req_addr_d;
      req_data_q <= req_data_d;
      load_q     <= load_d;
    end
  end

  assign dmemREN   = ren;
  assign dmemWEN   = wen;
  assign dmemaddr  = req_addr_q;
  assign dmemstore = req_data_q;
  assign mem_stall = nRST & stall;

  // Reset holds the MEM/WB side at bubble values even though these paths are combinational.
  assign Mem_o     = nRST ? mem_res : '0;
  assign npc_o     = nRST ? npc_i : '0;
  assign Addr_o    = nRST ? alu_out_i : '0;
  assign alu_out_o = nRST ? alu_out_i : '0;
  assign RegDest_o = nRST ? RegDest_i : '0;
  assign RegW_o    = nRST & ~stall & RegW_i;
  assign halt_o    = nRST & ~stall & halt_i;
  assign opcode_o  = (nRST && !stall) ? opcode_i : RTYPE;
endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with a transaction-level expectation model and per-cycle compare.
module tb_mem_stage;
  import cpu_types_pkg::*;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        ex_valid, squash, RegW_i, halt_i, dhit, ccinv;
  opcode_t     opcode_i;
  logic [31:0] alu_out_i, store_i, npc_i, dmemload, ccsnoopaddr;
  logic [4:0]  RegDest_i;
  logic        dmemREN, dmemWEN, mem_stall, RegW_o, halt_o;
  logic [31:0] dmemaddr, dmemstore, Mem_o, npc_o, Addr_o, alu_out_o;
  logic [4:0]  RegDest_o;
  opcode_t     opcode_o;

  mem_stage dut (
    .CLK(CLK), .nRST(nRST), .ex_valid(ex_valid), .squash(squash),
    .opcode_i(opcode_i), .alu_out_i(alu_out_i), .store_i(store_i), .npc_i(npc_i),
    .RegW_i(RegW_i), .RegDest_i(RegDest_i), .halt_i(halt_i), .dhit(dhit),
    .dmemload(dmemload), .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .mem_stall(mem_stall), .Mem_o(Mem_o), .npc_o(npc_o), .Addr_o(Addr_o),
    .RegW_o(RegW_o), .RegDest_o(RegDest_o), .halt_o(halt_o), .alu_out_o(alu_out_o),
    .opcode_o(opcode_o)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  // expected outputs for the current cycle, set by the stimulus tasks
  logic        e_stall, e_ren, e_wen, e_addr_chk, e_mem_chk;
  logic [31:0] e_addr, e_store, e_mem;
  logic        chk_en = 1'b0;
  int          ren_cyc, stall_cyc;
  logic [31:0] last_mem;
  // link model
  logic        m_lv;
  logic [31:0] m_la;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (chk_en) begin
      if (!nRST) begin
        check("rst_stall", {31'b0, mem_stall}, 32'd0);
        check("rst_ren", {31'b0, dmemREN}, 32'd0);
        check("rst_wen", {31'b0, dmemWEN}, 32'd0);
        check("rst_addr", dmemaddr, 32'd0);
        check("rst_store", dmemstore, 32'd0);
        check("rst_mem", Mem_o, 32'd0);
        check("rst_npc", npc_o, 32'd0);
        check("rst_aluout", alu_out_o, 32'd0);
        check("rst_regw", {31'b0, RegW_o}, 32'd0);
        check("rst_opcode", {26'b0, opcode_o}, {26'b0, RTYPE});
      end else begin
        check("stall", {31'b0, mem_stall}, {31'b0, e_stall});
        check("ren", {31'b0, dmemREN}, {31'b0, e_ren});
        check("wen", {31'b0, dmemWEN}, {31'b0, e_wen});
        if (e_addr_chk) check("addr", dmemaddr, e_addr);
        if (e_wen) check("store", dmemstore, e_store);
        if (e_mem_chk) begin
          check("mem_o", Mem_o, e_mem);
          last_mem = Mem_o;
        end
        check("npc", npc_o, npc_i);
        check("addr_o", Addr_o, alu_out_i);
        check("alu_out", alu_out_o, alu_out_i);
        check("regdest", {27'b0, RegDest_o}, {27'b0, RegDest_i});
        check("regw", {31'b0, RegW_o}, {31'b0, RegW_i & ~e_stall});
        check("halt", {31'b0, halt_o}, {31'b0, halt_i & ~e_stall});
        check("opcode", {26'b0, opcode_o}, e_stall ? {26'b0, RTYPE} : {26'b0, opcode_i});
      end
      ren_cyc   += int'(dmemREN);
      stall_cyc += int'(mem_stall);
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic exp_none();
    e_stall = 0; e_ren = 0; e_wen = 0; e_addr_chk = 0; e_mem_chk = 0;
  endtask

  task automatic snoop_model(input logic cc, input logic [31:0] cc_a);
`ifdef LLSC_EN
    if (cc && m_lv && ((cc_a & ~32'h3) == m_la)) m_lv = 0;
`endif
  endtask

  function automatic logic sc_ok(input logic [31:0] a);
`ifdef LLSC_EN
    return m_lv && (m_la == (a & ~32'h3));
`else
    return 1'b1;
`endif
  endfunction

  task automatic idle_cycle(input logic cc, input logic [31:0] cc_a);
    ex_valid = 0; squash = 0; opcode_i = RTYPE; RegW_i = 0;
    ccinv = cc; ccsnoopaddr = cc_a;
    exp_none();
    snoop_model(cc, cc_a);
    tick();
    ccinv = 0;
  endtask

  // One complete memory instruction: IDLE cycle, n REQ cycles (dhit on last), DONE.
  task automatic mem_op(input opcode_t op, input logic [31:0] a, input logic [31:0] d,
                        input int n, input logic [31:0] ld, input logic sq_req,
                        input logic cc, input logic [31:0] cc_a);
    logic rd;
    rd = (op == LW) || (op == LL);
    ex_valid = 1; squash = 0; opcode_i = op; alu_out_i = a; store_i = d;
    npc_i = $urandom; RegW_i = (op != SW); RegDest_i = 5'd7; halt_i = 0;
    ccinv = cc; ccsnoopaddr = cc_a; dhit = 0;
    snoop_model(cc, cc_a);
    exp_none();
    if (op == SC && !sc_ok(a)) begin
      e_mem_chk = 1; e_mem = 32'd0;
      tick();
      ccinv = 0;
    end else begin
      e_stall = 1;
      tick();
      ccinv = 0;
      for (int i = 0; i < n; i++) begin
        squash = sq_req; dhit = (i == n - 1); dmemload = (i == n - 1) ? ld : ~ld;
        e_ren = rd; e_wen = ~rd; e_addr_chk = 1; e_addr = a & ~32'h3; e_store = d;
        tick();
      end
      squash = 0; dhit = 0; dmemload = 32'd0;
      exp_none();
      e_mem_chk = (op != SW); e_mem = rd ? ld : 32'd1;
      tick();
`ifdef LLSC_EN
      if (op == LL) begin m_lv = 1; m_la = a & ~32'h3; end
      else if (op == SC) m_lv = 0;
      else if (op == SW && ((a & ~32'h3) == m_la)) m_lv = 0;
`endif
    end
    exp_none();
    ex_valid = 0; opcode_i = RTYPE; RegW_i = 0;
  endtask

  logic [31:0] sc_fail_val;

  initial begin
`ifdef LLSC_EN
    sc_fail_val = 32'd0;
`else
    sc_fail_val = 32'd1;
`endif
    m_lv = 0; m_la = 0; last_mem = 32'hFFFF_FFFF;
    nRST = 0; ex_valid = 0; squash = 0; opcode_i = RTYPE; alu_out_i = 0; store_i = 0;
    npc_i = 0; RegW_i = 0; RegDest_i = 0; halt_i = 0; dhit = 0; dmemload = 0;
    ccinv = 0; ccsnoopaddr = 0;
    exp_none(); e_addr = 0; e_store = 0; e_mem = 0;
    chk_en = 1;
    tick(); tick();
    nRST = 1;
    idle_cycle(0, 0);

    // LW with three REQ cycles
    ren_cyc = 0; stall_cyc = 0;
    mem_op(LW, 32'h100, 32'h0, 3, 32'hDEAD_BEEF, 0, 0, 0);
    check("lw_ren_cycles", ren_cyc, 32'd3);
    check("lw_stall_cycles", stall_cyc, 32'd4);
    check("lw_result", last_mem, 32'hDEAD_BEEF);

    // ADD passes through in the same cycle
    ex_valid = 1; opcode_i = RTYPE; alu_out_i = 32'h5; RegW_i = 1; RegDest_i = 5'd3;
    npc_i = 32'h44; exp_none();
    #1;
    check("add_alu_out", alu_out_o, 32'h5);
    check("add_regw", {31'b0, RegW_o}, 32'd1);
    check("add_stall", {31'b0, mem_stall}, 32'd0);
    check("add_strobes", {30'b0, dmemREN, dmemWEN}, 32'd0);
    tick();
    idle_cycle(0, 0);

    // LL then SC succeeds, second SC fails
    mem_op(LL, 32'h200, 32'h0, 1, 32'h1234_5678, 0, 0, 0);
    check("ll_result", last_mem, 32'h1234_5678);
    mem_op(SC, 32'h200, 32'hCAFE, 2, 32'h0, 0, 0, 0);
    check("sc1_result", last_mem, 32'd1);
    stall_cyc = 0;
    mem_op(SC, 32'h200, 32'hBEEF, 1, 32'h0, 0, 0, 0);
    check("sc2_result", last_mem, sc_fail_val);
    check("sc2_stall", stall_cyc, sc_fail_val == 32'd0 ? 32'd0 : 32'd2);

    // invalidate in a separate cycle, then in the SC's own cycle
    mem_op(LL, 32'h200, 32'h0, 1, 32'h1, 0, 0, 0);
    idle_cycle(1, 32'h200);
    mem_op(SC, 32'h200, 32'h9, 1, 32'h0, 0, 0, 0);
    check("sc_after_inv", last_mem, sc_fail_val);
    mem_op(LL, 32'h200, 32'h0, 2, 32'h2, 0, 0, 0);
    mem_op(SC, 32'h200, 32'h9, 1, 32'h0, 0, 1, 32'h203);
    check("sc_same_cycle_inv", last_mem, sc_fail_val);
    mem_op(LL, 32'h200, 32'h0, 1, 32'h3, 0, 0, 0);
    idle_cycle(1, 32'h204);
    mem_op(SC, 32'h200, 32'h9, 1, 32'h0, 0, 0, 0);
    check("sc_other_inv", last_mem, 32'd1);

    // unaligned SW, squash in IDLE, squash during REQ
    mem_op(SW, 32'h107, 32'h5555_AAAA, 2, 32'h0, 0, 0, 0);
    ex_valid = 1; squash = 1; opcode_i = SW; alu_out_i = 32'h300; store_i = 32'h77;
    RegW_i = 0; exp_none();
    tick();
    squash = 0;
    idle_cycle(0, 0);
    ren_cyc = 0;
    mem_op(SW, 32'h300, 32'h88, 3, 32'h0, 1, 0, 0);
    check("sw_squash_req_no_ren", ren_cyc, 32'd0);

    // reset during an SW request drops it and clears the link
    mem_op(LL, 32'h400, 32'h0, 1, 32'h4, 0, 0, 0);
    ex_valid = 1; opcode_i = SW; alu_out_i = 32'h300; store_i = 32'h99; RegW_i = 0;
    exp_none(); e_stall = 1;
    tick();
    e_stall = 1; e_wen = 1; e_addr_chk = 1; e_addr = 32'h300; e_store = 32'h99;
    tick();
    #2;
    nRST = 0;
    exp_none();
    #1;
    check("rst_async_wen", {31'b0, dmemWEN}, 32'd0);
    check("rst_async_addr", dmemaddr, 32'd0);
    check("rst_async_opcode", {26'b0, opcode_o}, {26'b0, RTYPE});
    ex_valid = 0; opcode_i = RTYPE;
    tick(); tick();
    nRST = 1;
    m_lv = 0;
    idle_cycle(0, 0);
    mem_op(SC, 32'h400, 32'h1, 1, 32'h0, 0, 0, 0);
    check("sc_after_reset", last_mem, sc_fail_val);
    idle_cycle(0, 0);

    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
